// File: rtl/neg_sample_framer.sv
// rtl/neg_sample_framer.sv - FIFO-buffered sample framer with post-frame idle gap
module neg_sample_framer #(
  parameter int N   = 8,
  parameter int K   = 16,
  parameter int D   = 16,
  parameter int GAP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [N-1:0]         in_data,
  input  logic                 ovf_clr,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [N-1:0]         out_data,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic [$clog2(D):0]   level,
  output logic                 overflow
);

  localparam int AW = $clog2(D);
  localparam int LW = AW + 1;
  localparam int FW = (K > 1) ? $clog2(K) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;

  logic [N-1:0]  mem [D];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [FW-1:0] fc;
  logic [GW-1:0] gc;
  logic [1:0]    state;
  logic [LW-1:0] level_nxt;
  logic          full;
  logic          wr;
  logic          drop;
  logic          xfer;
  logic          last;

  // A full FIFO blocks the write even if a read frees a slot this cycle.
  assign full  = (level == LW'(D));
  assign wr    = in_valid & ~full;
  assign drop  = in_valid & full;
  assign xfer  = out_valid & out_ready;
  assign last  = (fc == FW'(K - 1));

  assign out_valid   = (state == S_STREAM);
  assign out_data    = mem[rp];
  assign frame_start = out_valid & (fc == '0);
  assign frame_end   = out_valid & last;

  always_comb begin
    level_nxt = level;
    case ({wr, xfer})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      fc       <= '0;
      gc       <= '0;
      state    <= S_IDLE;
      overflow <= 1'b0;
    end else begin
      level <= level_nxt;
      if (wr)   wp <= wp + AW'(1);
      if (xfer) rp <= rp + AW'(1);
      if (xfer) fc <= last ? '0 : fc + FW'(1);

      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;

      // fc survives underruns so a frame may straddle an IDLE stretch.
      case (state)
        S_IDLE: begin
          if (level != '0) state <= S_STREAM;
        end
        S_STREAM: begin
          if (xfer && last) begin
            state <= S_GAP;
            gc    <= GW'(GAP - 1);
          end else if (xfer && (level_nxt == '0)) begin
            state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (gc == '0) state <= (level_nxt != '0) ? S_STREAM : S_IDLE;
          else          gc    <= gc - GW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neg_sample_framer.sv
// tb/tb_neg_sample_framer.sv - directed table and sequence bench for neg_sample_framer
module tb_neg_sample_framer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       ovf_clr;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       frame_start;
  logic       frame_end;
  logic [4:0] level;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  neg_sample_framer #(.N(8), .K(16), .D(16), .GAP(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .ovf_clr     (ovf_clr),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .level       (level),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic iv;
    int   id;
    logic ordy;
    logic clr;
    logic e_ov;
    int   e_data;
    logic e_fs;
    logic e_fe;
    int   e_level;
    logic e_ovf;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    ovf_clr  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int rcv;
    int sent;
    int gap_left;
    int cyc;
    bit saw_under;

    // single frame: samples -8..7, out_ready=1; row k = state after edge k
    for (int k = 0; k < 19; k++) begin
      tbl[k].iv      = (k < 16);
      tbl[k].id      = k - 8;
      tbl[k].ordy    = 1'b1;
      tbl[k].clr     = 1'b0;
      tbl[k].e_ov    = (k >= 1 && k <= 16);
      tbl[k].e_data  = k - 9;
      tbl[k].e_fs    = (k == 1);
      tbl[k].e_fe    = (k == 16);
      tbl[k].e_level = (k == 0 || k == 16) ? 1 : ((k >= 17) ? 0 : 2);
      tbl[k].e_ovf   = 1'b0;
    end

    rst = 1'b1; in_valid = 1'b0; in_data = '0; ovf_clr = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_level", level, 0);
    chk("reset_overflow", overflow, 0);

    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_out_valid", out_valid, 0);
      chk("idle_level", level, 0);
      chk("idle_overflow", overflow, 0);
    end

    for (int k = 0; k < 19; k++) begin
      in_valid  = tbl[k].iv;
      in_data   = 8'(tbl[k].id);
      out_ready = tbl[k].ordy;
      ovf_clr   = tbl[k].clr;
      step();
      chk($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].e_ov);
      if (tbl[k].e_ov) chk($sformatf("tbl%0d_out_data", k), $signed(out_data), tbl[k].e_data);
      chk($sformatf("tbl%0d_frame_start", k), frame_start, tbl[k].e_fs);
      chk($sformatf("tbl%0d_frame_end", k), frame_end, tbl[k].e_fe);
      chk($sformatf("tbl%0d_level", k), level, tbl[k].e_level);
      chk($sformatf("tbl%0d_overflow", k), overflow, tbl[k].e_ovf);
    end
    idle(3);

    // backpressure: fill to 16 with out_ready=0
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(20 + i);
      step();
    end
    chk("bp_level_full", level, 16);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head_held", $signed(out_data), 20);
    chk("bp_frame_start", frame_start, 1);
    chk("bp_overflow_pre", overflow, 0);
    in_data = 8'd99; step();
    chk("bp_drop_overflow", overflow, 1);
    chk("bp_drop_level", level, 16);
    chk("bp_drop_head", $signed(out_data), 20);
    in_valid = 1'b0; ovf_clr = 1'b1; step();
    chk("bp_clr_overflow", overflow, 0);
    in_valid = 1'b1; in_data = 8'd98; step();
    chk("bp_clr_and_drop", overflow, 1);
    chk("bp_clr_and_drop_level", level, 16);
    in_valid = 1'b0; step();
    chk("bp_clr_again", overflow, 0);
    ovf_clr = 1'b0;

    // full with simultaneous read and write
    in_valid = 1'b1; in_data = 8'd77; out_ready = 1'b1; step();
    chk("rw_full_level", level, 15);
    chk("rw_full_overflow", overflow, 1);
    chk("rw_full_next_head", $signed(out_data), 21);
    in_valid = 1'b0;
    for (int j = 1; j < 16; j++) begin
      chk($sformatf("drain%0d_valid", j), out_valid, 1);
      chk($sformatf("drain%0d_data", j), $signed(out_data), 20 + j);
      chk($sformatf("drain%0d_fe", j), frame_end, (j == 15));
      step();
    end
    chk("drain_gap_valid", out_valid, 0);
    chk("drain_level", level, 0);
    idle(3);

    // wrap-around: 40 samples, input on even cycles, out_ready toggling 1,0
    rcv = 0; sent = 0; gap_left = 0; cyc = 0;
    while (rcv < 40 && cyc < 400) begin
      in_valid  = ((cyc % 2) == 0) && (sent < 40);
      in_data   = 8'(sent);
      out_ready = ((cyc % 2) == 0);
      if (gap_left > 0) begin
        chk("wrap_gap_low", out_valid, 0);
        gap_left--;
      end
      if (out_valid && out_ready) begin
        chk("wrap_data", $signed(out_data), rcv);
        chk("wrap_fs", frame_start, (rcv % 16) == 0);
        chk("wrap_fe", frame_end, (rcv % 16) == 15);
        if (frame_end) gap_left = 2;
        rcv++;
      end
      if (in_valid) sent++;
      step();
      cyc++;
    end
    chk("wrap_received", rcv, 40);
    in_valid = 1'b0; out_ready = 1'b0;
    idle(2);

    // asynchronous reset between edges with data buffered mid-frame
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(50 + i); step();
    end
    in_valid = 1'b0;
    chk("prerst_level", level, 3);
    chk("prerst_valid", out_valid, 1);
    chk("prerst_overflow", overflow, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_overflow", overflow, 0);
    chk("arst_frame_start", frame_start, 0);
    chk("arst_frame_end", frame_end, 0);
    #2 rst = 1'b0;
    step();

    // underrun mid-frame: 5 samples, 3-cycle pause, 11 samples
    rcv = 0; sent = 0; gap_left = 0; cyc = 0; saw_under = 0;
    out_ready = 1'b1;
    while ((rcv < 16 || gap_left > 0) && cyc < 100) begin
      in_valid = (cyc < 5) || (cyc >= 8 && cyc < 19);
      in_data  = 8'(100 + sent);
      if (gap_left > 0) begin
        chk("ur_gap_low", out_valid, 0);
        gap_left--;
      end
      if (!out_valid && rcv > 0 && rcv < 16) saw_under = 1;
      if (out_valid && out_ready) begin
        chk("ur_data", $signed(out_data), 100 + rcv);
        chk("ur_fs", frame_start, rcv == 0);
        chk("ur_fe", frame_end, rcv == 15);
        if (frame_end) gap_left = 2;
        rcv++;
      end
      if (in_valid) sent++;
      step();
      cyc++;
    end
    chk("ur_received", rcv, 16);
    chk("ur_saw_underrun", saw_under, 1);
    chk("ur_final_level", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/neg_sample_framer.md
# neg_sample_framer

Upstream stage for the negative-sample counter. It buffers a stream of signed samples in a small FIFO and delivers them to the counter in frames of K samples using a valid/ready handshake. After each frame it inserts a fixed idle gap so the downstream stage can sample its running count at a clean frame boundary. It also reports FIFO occupancy and a sticky overflow flag when input samples are dropped.

## Interface
- N, 8, sample width in bits (two's complement signed)
- K, 16, samples per frame (≥2)
- D, 16, FIFO depth (power of two, ≥2)
- GAP, 2, idle cycles inserted after each frame (≥1)

- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  a sample is presented on in_data this cycle
- in_data  input  N  signed sample
- ovf_clr  input  1  clears the sticky overflow flag
- out_ready  input  1  downstream accepts out_data this cycle
- out_valid  output  1  out_data holds a valid sample
- out_data  output  N  FIFO head sample (first-word fall-through)
- frame_start  output  1  the current out_data is sample 0 of a frame
- frame_end  output  1  the current out_data is sample K-1 of a frame
- level  output  $clog2(D)+1  FIFO occupancy, 0..D
- overflow  output  1  sticky; set when a sample was dropped

## Operation
- FIFO: memory of D×N, write pointer wp, read pointer rp, each $clog2(D) bits and wrapping modulo D. The level register is kept separately.
- Write: when in_valid=1 and level<D, store in_data at wp and increment wp.
- Drop: when in_valid=1 and level==D, discard the sample and set overflow. A read in the same cycle does not free a slot for this write, because full blocks the write.
- Read (transfer): a transfer occurs when out_valid=1 and out_ready=1. It increments rp.
- Level update: +1 on write only, -1 on transfer only, unchanged when both or neither occur.
- out_data = mem[rp] combinationally. It is don't-care while out_valid=0.
- The frame counter fc runs 0..K-1. It increments on each transfer and wraps to 0 after the transfer at fc=K-1.
- frame_start = out_valid & (fc==0).
- frame_end = out_valid & (fc==K-1).
- FSM states:
  - IDLE: out_valid=0. Go to STREAM when level>0.
  - STREAM: out_valid=1. On a transfer with fc==K-1, go to GAP and load the gap counter gc=GAP-1. If level becomes 0 after a transfer that is not the frame end, go to IDLE; fc is kept, so frames span underruns.
  - GAP: out_valid=0. Decrement gc each cycle. When gc==0, go to STREAM if level>0 (counting the current cycle's write), else IDLE.
- overflow: set by a drop, cleared by ovf_clr. If both happen in the same cycle, set wins.
- out_ready=0 in STREAM holds out_data and fc stable indefinitely (no timeout).

## Timing
- Reset (asynchronous, immediate):
  - wp=rp=0, level=0, fc=0, gc=0, state=IDLE.
  - out_valid=0, frame_start=0, frame_end=0, overflow=0.
  - FIFO memory is not reset.
- Reset mid-frame discards all buffered data and restarts frame numbering at 0.
- Latency into an empty FIFO: a sample written at edge t is on out_data with out_valid=1 after edge t+1, because IDLE→STREAM takes one edge.
- Back-to-back: in STREAM with out_ready=1 and level>0, one transfer occurs per cycle.
- Frame boundary: the transfer at fc=K-1 happens at edge t. out_valid is then 0 for exactly GAP cycles (edges t+1..t+GAP). The next frame_start can be seen no earlier than after edge t+GAP.
- Writes continue during GAP and IDLE. Level may reach D during a long GAP, and drops then follow the full rule.
- level and overflow are registered outputs and reflect the state after the last edge.

## Test plan
- Reset then idle: with no in_valid, out_valid=0, level=0, overflow=0 for 10 cycles.
  - Then assert rst asynchronously between edges: all outputs clear immediately.
- Single frame, K=16, GAP=2, out_ready=1: write samples -8..7 on 16 consecutive cycles.
  - out_data shows -8..7 in order, one per cycle.
  - frame_start coincides with -8 and frame_end with 7.
  - out_valid is low for 2 cycles after the last transfer.
- Backpressure: fill with 16 samples while out_ready=0.
  - level reaches 16 and out_data is held at the first sample.
  - A 17th in_valid is dropped and sets overflow.
  - ovf_clr then clears overflow.
  - ovf_clr pulsed together with a drop leaves overflow=1.
- Full with simultaneous read/write: level=16 with out_ready=1 and in_valid=1 on the same cycle.
  - The sample is dropped, level goes to 15, overflow=1.
- Wrap-around: stream 40 samples (values 0..39) with out_ready toggling 1,0,1,0.
  - All samples arrive in order with none lost; pointers wrap past 15.
  - frame_end marks values 15 and 31, each followed by a 2-cycle gap.
- Underrun mid-frame: deliver 5 samples, pause input for 3 cycles, then deliver 11 more.
  - out_valid drops during the pause and fc is preserved.
  - frame_end occurs on the 16th sample overall.
